// File: rtl/rv_imem_responder.sv
// rv_imem_responder: instruction-fetch responder backed by a word-organised
// on-chip array. A fetch is sampled in IDLE and acked a fixed LATENCY cycles
// later. A side load port writes full words into the array in any state.
module rv_imem_responder #(
    parameter int unsigned                MEM_ADDR_WIDTH = 64,
    parameter int unsigned                MEM_DATA_WIDTH = 64,
    parameter int unsigned                MEM_DEPTH      = 1024,
    parameter logic [MEM_ADDR_WIDTH-1:0]  MEM_BASE       = '0,
    parameter int unsigned                LATENCY        = 2
) (
    input  logic                      clk_i,
    input  logic                      arst_ni,
    input  logic                      imem_req_i,
    input  logic [MEM_ADDR_WIDTH-1:0] imem_addr_i,
    output logic [MEM_DATA_WIDTH-1:0] imem_data_o,
    output logic                      imem_ack_o,
    input  logic                      load_en_i,
    input  logic [MEM_ADDR_WIDTH-1:0] load_addr_i,
    input  logic [MEM_DATA_WIDTH-1:0] load_data_i
);

    // Byte-offset bits inside one word; these are dropped (fetches align down).
    localparam int unsigned OFF_W = $clog2(MEM_DATA_WIDTH / 8);
    localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [MEM_ADDR_WIDTH-1:0] DEPTH_A = MEM_ADDR_WIDTH'(MEM_DEPTH);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
    localparam logic SINGLE_CYCLE = (LATENCY == 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

    // An address hits the array when it is at or above the base (no borrow in
    // the full-width subtraction) and its word index is below the depth.
    function automatic logic addr_in_range(input logic [MEM_ADDR_WIDTH-1:0] addr);
        logic [MEM_ADDR_WIDTH:0] diff;
        diff = {1'b0, addr} - {1'b0, MEM_BASE};
        return (!diff[MEM_ADDR_WIDTH]) &&
               ((diff[MEM_ADDR_WIDTH-1:0] >> OFF_W) < DEPTH_A);
    endfunction

    // Word index of a byte address; only meaningful when addr_in_range holds.
    function automatic logic [IDX_W-1:0] addr_index(input logic [MEM_ADDR_WIDTH-1:0] addr);
        return IDX_W'((addr - MEM_BASE) >> OFF_W);
    endfunction

    logic [MEM_DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    state_e                    state_q, state_d;
    logic [3:0]                cnt_q, cnt_d;
    logic [MEM_DATA_WIDTH-1:0] hold_q, hold_d;
    logic [MEM_DATA_WIDTH-1:0] data_q, data_d;
    logic                      ack_q, ack_d;

    logic                      fetch_hit_s;
    logic [IDX_W-1:0]          fetch_idx_s;
    logic                      load_hit_s;
    logic [IDX_W-1:0]          load_idx_s;
    logic [MEM_DATA_WIDTH-1:0] rd_word_s;

    assign fetch_hit_s = addr_in_range(imem_addr_i);
    assign fetch_idx_s = addr_index(imem_addr_i);
    assign load_hit_s  = addr_in_range(load_addr_i);
    assign load_idx_s  = addr_index(load_addr_i);

    // Array read; out-of-range fetches see all-zeros (an illegal instruction).
    always_comb begin
        rd_word_s = '0;
        if (fetch_hit_s) begin
            rd_word_s = mem_q[fetch_idx_s];
        end else begin
            rd_word_s = '0;
        end
    end

    // Load port write; the read above sees the old word at the same edge.
    always_ff @(posedge clk_i) begin
        if (load_en_i && load_hit_s) begin
            mem_q[load_idx_s] <= load_data_i;
        end
    end

    // State, latency counter, sampled word and output registers.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            hold_q  <= '0;
            data_q  <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
        end
    end

    // Next-state and counter: sample in IDLE, count down in WAIT, one ACK cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (imem_req_i) begin
                    cnt_d   = CNT_INIT;
                    state_d = SINGLE_CYCLE ? ST_ACK : ST_WAIT;
                end else begin
                    cnt_d   = cnt_q;
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_ACK;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_ACK: begin
                cnt_d   = cnt_q;
                state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = 4'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs: latch the word at sample time, present it on entry to ACK.
    always_comb begin
        hold_d = hold_q;
        data_d = data_q;
        ack_d  = 1'b0;
        if ((state_q == ST_IDLE) && imem_req_i) begin
            hold_d = rd_word_s;
        end else begin
            hold_d = hold_q;
        end
        if ((state_d == ST_ACK) && (state_q != ST_ACK)) begin
            ack_d  = 1'b1;
            data_d = (state_q == ST_IDLE) ? rd_word_s : hold_q;
        end else begin
            ack_d  = 1'b0;
            data_d = data_q;
        end
    end

    assign imem_data_o = data_q;
    assign imem_ack_o  = ack_q;

endmodule

// File: tb/tb_rv_imem_responder.sv
// Bench for rv_imem_responder: two instances (LATENCY=2 and LATENCY=1) driven
// with directed fetches and random traffic, checked every cycle against a
// transaction-level reference model (array contents plus ack timing).
module tb_rv_imem_responder;

    localparam int          DEPTH = 1024;
    localparam logic [63:0] BASE  = 64'd0;
    localparam int          LAT0  = 2;
    localparam int          LAT1  = 1;
    localparam logic [63:0] WORD0 = 64'h0000_0013_0000_0093;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        req_s;
    logic [1:0][63:0]  addr_s;
    logic [1:0]        load_en_s;
    logic [1:0][63:0]  load_addr_s;
    logic [1:0][63:0]  load_data_s;
    wire  [1:0]        ack_w;
    wire  [1:0][63:0]  data_w;

    // Reference model state
    logic [63:0] mdl_mem [2][DEPTH];
    int          edge_n = 0;
    int          free_at [2];
    int          ack_edge [2];
    logic [63:0] pend [2];
    logic [63:0] exp_data [2];
    logic        exp_ack [2];

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    rv_imem_responder #(
        .MEM_ADDR_WIDTH(64), .MEM_DATA_WIDTH(64), .MEM_DEPTH(DEPTH),
        .MEM_BASE(BASE), .LATENCY(LAT0)
    ) u_dut0 (
        .clk_i(clk), .arst_ni(rst_n),
        .imem_req_i(req_s[0]), .imem_addr_i(addr_s[0]),
        .imem_data_o(data_w[0]), .imem_ack_o(ack_w[0]),
        .load_en_i(load_en_s[0]), .load_addr_i(load_addr_s[0]), .load_data_i(load_data_s[0])
    );

    rv_imem_responder #(
        .MEM_ADDR_WIDTH(64), .MEM_DATA_WIDTH(64), .MEM_DEPTH(DEPTH),
        .MEM_BASE(BASE), .LATENCY(LAT1)
    ) u_dut1 (
        .clk_i(clk), .arst_ni(rst_n),
        .imem_req_i(req_s[1]), .imem_addr_i(addr_s[1]),
        .imem_data_o(data_w[1]), .imem_ack_o(ack_w[1]),
        .load_en_i(load_en_s[1]), .load_addr_i(load_addr_s[1]), .load_data_i(load_data_s[1])
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int lat(input int k);
        return (k == 0) ? LAT0 : LAT1;
    endfunction

    function automatic logic [63:0] model_read(input int k, input logic [63:0] a);
        logic [63:0] w;
        w = (a - BASE) / 64'd8;
        if (w < 64'(DEPTH)) return mdl_mem[k][int'(w)];
        return 64'd0;
    endfunction

    function automatic logic [63:0] rand_addr();
        int r;
        r = $urandom_range(0, 15);
        if (r == 0) return {$urandom, $urandom};
        if (r == 1) return 64'(DEPTH * 8 + $urandom_range(0, 63));
        return 64'($urandom_range(0, DEPTH * 8 - 1));
    endfunction

    // Transaction model: a request seen while free is sampled; its ack lands
    // LATENCY-1 edges later and the next sample may happen two edges after that.
    always @(posedge clk) begin
        edge_n = edge_n + 1;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                free_at[k]  = 0;
                ack_edge[k] = -1;
                exp_ack[k]  = 1'b0;
                exp_data[k] = 64'd0;
            end else begin
                if (req_s[k] && (edge_n >= free_at[k])) begin
                    pend[k]     = model_read(k, addr_s[k]);
                    ack_edge[k] = edge_n + lat(k) - 1;
                    free_at[k]  = edge_n + lat(k) + 1;
                end
                exp_ack[k] = (edge_n == ack_edge[k]);
                if (exp_ack[k]) exp_data[k] = pend[k];
            end
            if (load_en_s[k]) begin
                logic [63:0] w;
                w = (load_addr_s[k] - BASE) / 64'd8;
                if (w < 64'(DEPTH)) mdl_mem[k][int'(w)] = load_data_s[k];
            end
        end
    end

    // Cycle-by-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("ack%0d", k), {63'd0, ack_w[k]}, {63'd0, exp_ack[k]});
                check($sformatf("data%0d", k), data_w[k], exp_data[k]);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic fetch(input int k, input logic [63:0] a, input bit keep,
                         output logic [63:0] d, output int cnt);
        req_s[k]  = 1'b1;
        addr_s[k] = a;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!ack_w[k] && cnt < 40);
        if (!ack_w[k]) check("ack_timeout", {63'd0, ack_w[k]}, 64'd1);
        d = data_w[k];
        #1;
        if (!keep) req_s[k] = 1'b0;
    endtask

    initial begin
        logic [63:0] d;
        logic [63:0] old;
        int          c;
        int          r;

        rst_n = 1'b1;
        req_s = '0; addr_s = '0; load_en_s = '0; load_addr_s = '0; load_data_s = '0;
        for (int k = 0; k < 2; k++) begin
            free_at[k] = 0; ack_edge[k] = -1; exp_ack[k] = 1'b0;
            exp_data[k] = 64'd0; pend[k] = 64'd0;
        end
        #2;
        rst_n  = 1'b0;
        chk_en = 1'b1;
        repeat (3) step();
        check("rst_ack", {63'd0, ack_w[0]}, 64'd0);
        check("rst_data", data_w[0], 64'd0);
        rst_n = 1'b1;
        step();

        // Preload both arrays
        for (int i = 0; i < DEPTH; i++) begin
            load_en_s      = 2'b11;
            load_addr_s[0] = 64'(i) * 64'd8;
            load_addr_s[1] = 64'(i) * 64'd8;
            load_data_s[0] = (i == 0) ? WORD0 : {$urandom, $urandom};
            load_data_s[1] = {$urandom, $urandom};
            step();
        end
        load_en_s = '0;
        step();

        // Single fetch of word 0
        fetch(0, 64'h0, 1'b0, d, c);
        check("t1_data", d, WORD0);
        check("t1_lat", 64'(c), 64'(LAT0));
        step();

        // Back-to-back with req held high
        fetch(0, 64'h0, 1'b1, d, c);
        check("t2_d0", d, WORD0);
        fetch(0, 64'h8, 1'b0, d, c);
        check("t2_d1", d, mdl_mem[0][1]);
        check("t2_gap", 64'(c), 64'(LAT0 + 1));
        step();

        // LATENCY=1 with a misaligned address
        fetch(1, 64'hC, 1'b0, d, c);
        check("t3_data", d, mdl_mem[1][1]);
        check("t3_lat", 64'(c), 64'(LAT1));
        step();

        // Out-of-range fetch and load
        fetch(0, 64'(DEPTH * 8), 1'b0, d, c);
        check("t4_data", d, 64'd0);
        check("t4_lat", 64'(c), 64'(LAT0));
        step();
        load_en_s[0] = 1'b1; load_addr_s[0] = 64'(DEPTH * 8); load_data_s[0] = 64'hDEAD_BEEF_DEAD_BEEF;
        step();
        load_en_s[0] = 1'b0;
        step();
        fetch(0, 64'h0, 1'b0, d, c);
        check("t4_w0", d, WORD0);
        step();
        fetch(0, 64'(DEPTH * 8 - 8), 1'b0, d, c);
        check("t4_wlast", d, mdl_mem[0][DEPTH - 1]);
        step();

        // Load/fetch collision on word 3
        old = mdl_mem[0][3];
        load_en_s[0] = 1'b1; load_addr_s[0] = 64'h18; load_data_s[0] = 64'hAAAA_AAAA_AAAA_AAAA;
        fetch(0, 64'h18, 1'b0, d, c);
        load_en_s[0] = 1'b0;
        check("t5_old", d, old);
        step();
        fetch(0, 64'h18, 1'b0, d, c);
        check("t5_new", d, 64'hAAAA_AAAA_AAAA_AAAA);
        step();

        // Reset while waiting
        req_s[0] = 1'b1; addr_s[0] = 64'h10;
        step();
        rst_n = 1'b0;
        req_s[0] = 1'b0;
        step();
        check("t6_ack", {63'd0, ack_w[0]}, 64'd0);
        check("t6_data", data_w[0], 64'd0);
        step();
        check("t6_ack2", {63'd0, ack_w[0]}, 64'd0);
        rst_n = 1'b1;
        step();
        fetch(0, 64'h20, 1'b0, d, c);
        check("t6_after", d, mdl_mem[0][4]);
        check("t6_lat", 64'(c), 64'(LAT0));
        step();

        // Random traffic, checked by the model every cycle
        repeat (2500) begin
            for (int k = 0; k < 2; k++) begin
                if (!req_s[k]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        req_s[k]  = 1'b1;
                        addr_s[k] = rand_addr();
                    end
                end else begin
                    r = $urandom_range(0, 99);
                    if (r < 5) req_s[k] = 1'b0;
                    else if (r < 15 || ack_w[k]) addr_s[k] = rand_addr();
                end
                load_en_s[k]   = ($urandom_range(0, 3) == 0);
                load_addr_s[k] = rand_addr();
                load_data_s[k] = {$urandom, $urandom};
            end
            step();
        end
        req_s = '0;
        load_en_s = '0;
        repeat (5) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rv_imem_responder.md
Name: rv_imem_responder

Overview:
- Memory-side responder for the core instruction-fetch interface (imem_req/imem_addr/imem_data/imem_ack).
- Serves fetches from a word-organised on-chip array with a fixed, parameterised latency.
- Has a side load port so benches and the boot loader can preload program images.
- Sits between the rv_g_core fetch port and the SoC fabric; also serves as the standalone fetch model in core-level benches.

Parameters:
- MEM_ADDR_WIDTH, 64, byte-address width of the fetch and load ports.
- MEM_DATA_WIDTH, 64, word width in bits; power of two, at least 32.
- MEM_DEPTH, 1024, number of words in the array.
- MEM_BASE, 0, byte address of word 0; must be aligned to MEM_DATA_WIDTH/8.
- LATENCY, 2, cycles from request sample to ack; legal values 1..15.

Ports:
- clk_i  in  1  clock, rising edge.
- arst_ni  in  1  asynchronous active-low reset.
- imem_req_i  in  1  fetch request; held high by the core until ack.
- imem_addr_i  in  MEM_ADDR_WIDTH  fetch byte address; stable while req is high.
- imem_data_o  out  MEM_DATA_WIDTH  fetched word.
- imem_ack_o  out  1  one-cycle response strobe.
- load_en_i  in  1  array write enable.
- load_addr_i  in  MEM_ADDR_WIDTH  write byte address.
- load_data_i  in  MEM_DATA_WIDTH  write data, full word.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-low on arst_ni.
- Reset values: imem_ack_o=0, imem_data_o=0, FSM=IDLE, latency counter=0. Array contents are not reset.
- Address mapping:
  - Word index = (addr - MEM_BASE) >> log2(MEM_DATA_WIDTH/8).
  - Low byte-offset bits are ignored; fetches are aligned down.
  - In range means addr >= MEM_BASE and index < MEM_DEPTH. Subtraction is full MEM_ADDR_WIDTH, unsigned.
- FSM states IDLE, WAIT, ACK:
  - IDLE: at an edge with imem_req_i=1, sample the request and read the array at the index.
    - Out-of-range reads return all-zeros (an illegal instruction).
    - Load the counter with LATENCY-1.
    - Go to ACK if LATENCY=1, else go to WAIT.
  - WAIT: decrement the counter each edge. At the edge where the counter reaches 1, go to ACK.
  - ACK: imem_ack_o=1 for exactly this cycle, and imem_data_o presents the sampled word. The next edge returns to IDLE.
- Timing: if the request is sampled at edge N, ack is high in the cycle following edge N+LATENCY-1.
- Handshake:
  - The edge at which ack is high completes the transaction; imem_req_i is not sampled on that edge.
  - The next request can be sampled no earlier than the following edge.
  - Maximum throughput is one fetch per LATENCY+1 cycles.
- imem_data_o is registered. It updates only on entry to ACK and holds its value until the next ACK.
- Changes to imem_req_i/imem_addr_i while in WAIT or ACK are ignored; the address is latched at sample.
- A request dropped before ack is still completed and acked.
- Load port:
  - When load_en_i=1, write the array at the load index at the edge, in any FSM state.
  - Out-of-range loads are dropped silently.
- Load vs fetch collision: same word at the sample edge gives read-before-write, so the fetch returns the old data. Loads after the sample edge do not affect the in-flight fetch.
- Reset mid-transaction: the fetch is abandoned, no ack is issued, and the FSM returns to IDLE on release.

Test Plan:
- Preload word 0 with 0x0000_0013_0000_0093 (MEM_BASE=0, LATENCY=2). Hold req with addr=0x0 sampled at edge 10 -> ack high exactly one cycle, after edge 11, with data=0x0000_0013_0000_0093. Ack low in all other cycles.
- Back-to-back fetches: req held continuously, address 0x8 after the first ack (LATENCY=2) -> second sample at the edge after the ack edge. Acks spaced 3 cycles apart, data matches words 0 and 1.
- LATENCY=1, addr=0x0C (misaligned) -> ack in the cycle after sampling, data = word 1.
- Out-of-range: addr=MEM_DEPTH*8 = 0x2000 -> ack after LATENCY cycles, data=0. A load to 0x2000 leaves all words unchanged.
- Collision: load word 3 with 0xAAAA… at the same edge a fetch of 0x18 is sampled -> that fetch returns the old value. An immediate refetch returns 0xAAAA….
- Reset asserted in WAIT -> ack stays 0, data=0. After release, a new request completes normally with correct LATENCY.
